// File: rtl/if_prefetch_unit_pkg.sv
// cpu_pkg: shared CPU front-end types and constants.
// Rev 1.0
`default_nettype none

package cpu_pkg;
  localparam int ADDR_W  = 64;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

`default_nettype wire

// File: rtl/if_prefetch_unit_if.sv
// Fetch-stage bus interfaces: imem request/response and decode delivery.
// Rev 1.0
`default_nettype none

interface if_prefetch_imem_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

interface if_prefetch_inst_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W
);
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );
  modport slave (
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

`default_nettype wire

// File: rtl/if_prefetch_unit_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush and occupancy count.
// Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic                       flush,
  input  wire logic [WIDTH-1:0]           din,
  output logic      [WIDTH-1:0]           dout,
  output logic      [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign count = r_count;
endmodule

`default_nettype wire

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: credit-limited in-order instruction prefetch with redirect flush.
// Rev 1.0 -- define IF_PREFETCH_PERF_EN to add saturating perf counters.
`default_nettype none

module if_prefetch_unit #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  if_prefetch_imem_if.master     imem,
  if_prefetch_inst_if.master     dec,
  input  wire logic              redirect_valid,
  input  wire logic [ADDR_W-1:0] redirect_pc
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic      [31:0]       perf_fetched,
  output logic      [31:0]       perf_dropped,
  output logic      [31:0]       perf_stall
`endif
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + ADDR_W;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop;
  logic [CW-1:0]     w_drop_nxt;
  logic [CW-1:0]     w_drop_redir;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_inflight;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [EW-1:0]     w_head;
  logic              w_empty;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_keep;
  logic              w_pop;

  assign w_redir_pc   = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_inflight   = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_empty      = (w_count == '0);
  // Credit covers both buffered and in-flight words, so responses never need backpressure.
  assign w_req_valid  = !rst && (r_state == RUN) && !redirect_valid
                        && (w_inflight < (CW+1)'(DEPTH));
  assign w_accept     = w_req_valid && imem.imem_req_ready;
  assign w_keep       = imem.imem_rsp_valid && !redirect_valid && (r_drop == '0);
  assign w_pop        = !w_empty && dec.inst_ready && !redirect_valid;
  assign w_drop_redir = r_outstanding - CW'(imem.imem_rsp_valid);

  always_comb begin
    w_drop_nxt = r_drop;
    if (redirect_valid)
      w_drop_nxt = w_drop_redir;
    else if (imem.imem_rsp_valid && (r_drop != '0))
      w_drop_nxt = r_drop - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem.imem_rsp_valid);
      r_drop        <= w_drop_nxt;

      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
        if (w_keep)   r_rsp_pc   <= r_rsp_pc + ADDR_W'(PC_STEP);
      end

      // A redirect in DRAIN holds DRAIN for one cycle even if nothing is left to drop.
      case (r_state)
        RUN:     if (redirect_valid && (w_drop_nxt != '0)) r_state <= DRAIN;
        DRAIN:   if (!redirect_valid && (w_drop_nxt == '0)) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_keep),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   ({imem.imem_rsp_data, r_rsp_pc}),
    .dout  (w_head),
    .count (w_count)
  );

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_fetch_pc;
  assign dec.inst_valid      = !w_empty;
  assign dec.inst_data       = w_empty ? '0 : w_head[EW-1:ADDR_W];
  assign dec.inst_pc         = w_empty ? '0 : w_head[ADDR_W-1:0];

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_keep && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (imem.imem_rsp_valid && !w_keep && (r_perf_dropped != '1))
        r_perf_dropped <= r_perf_dropped + 32'd1;
      if (w_empty && (r_state == RUN) && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
  assign perf_stall   = r_perf_stall;
`endif
endmodule

`default_nettype wire
